// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register-file write arbiter.
package regfile_pkg;

    localparam int unsigned CNT_W = 16;

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? int'($clog2(depth)) : 1;
    endfunction

endpackage

// File: rtl/arb_select.sv
// One-hot grant selection: scans requesters starting just after ptr, first valid wins.
module arb_select #(
    parameter int unsigned N_REQ = 2,
    localparam int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PTR_W-1:0] ptr,
    input  logic             hold,
    output logic [N_REQ-1:0] grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        idx   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        if (hold) begin
            grant = '0;
        end
    end

endmodule

// File: rtl/regfile_wr_arb.sv
// Arbitrates N_REQ write requesters onto a single regfile write port with read-hazard flags.
// Define REGFILE_WR_ARB_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned N_REQ = 2,
    localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [N_REQ*WIDTH-1:0]  i_req_data,
    output logic [N_REQ-1:0]        o_req_ready,
    input  logic                    i_hold,
    output logic                    o_wr_en,
    output logic [ADDR_W-1:0]       o_wr_addr,
    output logic [WIDTH-1:0]        o_wr_data,
    input  logic [ADDR_W-1:0]       i_rd1_addr,
    input  logic [ADDR_W-1:0]       i_rd2_addr,
    output logic                    o_rd1_hazard,
    output logic                    o_rd2_hazard,
    output logic [CNT_W-1:0]        o_wr_count
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    logic [ADDR_W-1:0] req_addr [N_REQ];
    logic [WIDTH-1:0]  req_data [N_REQ];
    logic [N_REQ-1:0]  grant;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  scan;
    logic              xfer;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [WIDTH-1:0]  wr_data_q;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_addr[g] = i_req_addr[g*ADDR_W +: ADDR_W];
        assign req_data[g] = i_req_data[g*WIDTH +: WIDTH];
    end

    arb_select #(
        .N_REQ (N_REQ)
    ) u_arb_select (
        .valid (i_req_valid),
        .ptr   (ptr),
        .hold  (i_hold),
        .grant (grant)
    );

    assign o_req_ready = rst ? '0 : grant;
    assign xfer        = |o_req_ready;

    always_comb begin
        grant_idx = '0;
        scan      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (o_req_ready[scan]) begin
                grant_idx = scan;
            end
            scan = scan + 1'b1;
        end
    end

`ifdef REGFILE_WR_ARB_RR_EN
    logic [PTR_W-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PTR_W'(N_REQ - 1);
        end else if (xfer) begin
            ptr_q <= grant_idx;
        end
    end

    assign ptr = ptr_q;
`else
    // Constant start point makes the scan begin at index 0: plain fixed priority.
    assign ptr = PTR_W'(N_REQ - 1);
`endif

    // Count is bumped on the edge that launches the write, so it includes the visible one.
    always_comb begin
        wr_count_d = wr_count_q;
        if (xfer && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_count_q <= '0;
        end else begin
            wr_en_q    <= xfer;
            wr_count_q <= wr_count_d;
            if (xfer) begin
                wr_addr_q <= req_addr[grant_idx];
                wr_data_q <= req_data[grant_idx];
            end
        end
    end

    // Reset cancels a write already sitting in the output stage.
    assign o_wr_en      = wr_en_q & ~rst;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_wr_count   = wr_count_q;
    assign o_rd1_hazard = o_wr_en && (i_rd1_addr == wr_addr_q);
    assign o_rd2_hazard = o_wr_en && (i_rd2_addr == wr_addr_q);

endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have parameter N_REQ, default 2, number of write requesters; legal range 2..4.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_req_valid  input  N_REQ  per-requester write request.
REQ-007 SHALL have port i_req_addr  input  N_REQ*ADDR_W  packed target addresses; requester k at bits [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port i_req_data  input  N_REQ*WIDTH  packed write data; requester k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port o_req_ready  output  N_REQ  per-requester grant (accept strobe).
REQ-010 SHALL have port i_hold  input  1  blocks all grants this cycle.
REQ-011 SHALL have port o_wr_en  output  1  drives regfile write enable.
REQ-012 SHALL have port o_wr_addr  output  ADDR_W  drives regfile write address.
REQ-013 SHALL have port o_wr_data  output  WIDTH  drives regfile write data.
REQ-014 SHALL have port i_rd1_addr / i_rd2_addr  input  ADDR_W each  regfile read addresses under hazard check.
REQ-015 SHALL have port o_rd1_hazard / o_rd2_hazard  output  1 each  read address matches in-flight write.
REQ-016 SHALL have port o_wr_count  output  16  saturating count of committed writes.

Function
REQ-017 SHALL combinationally assert at most one o_req_ready bit, only for a requester with valid=1, and none when i_hold=1 or rst=1.
REQ-018 SHALL treat valid&ready as a transfer; a requester SHALL keep valid, addr and data stable until its ready.
REQ-019 SHALL register the granted addr/data into the output stage; o_wr_en=1 exactly one cycle after the transfer, else 0 (latency 1, throughput 1 write/cycle).
REQ-020 SHALL hold o_wr_addr/o_wr_data at their last values when o_wr_en=0.
REQ-021 SHALL assert o_rdN_hazard combinationally when o_wr_en=1 and i_rdN_addr==o_wr_addr; 0 otherwise.
REQ-022 SHALL increment o_wr_count on each cycle with o_wr_en=1, saturating at 16'hFFFF (no wrap).
REQ-023 SHALL accept writes to any address including 0; no address filtering.
REQ-024 SHALL let simultaneous requests to the same address be granted in arbitration order, last commit wins.

Reset
REQ-025 SHALL on rst=1 at a clock edge clear o_wr_en to 0, o_wr_addr and o_wr_data to 0, o_wr_count to 0, round-robin pointer to N_REQ-1.
REQ-026 SHALL drop a grant coinciding with rst=1; an in-flight write SHALL be cancelled (o_wr_en=0 next cycle).

Configuration
REQ-027 SHALL with macro REGFILE_WR_ARB_RR_EN defined use round-robin: search starts at index (pointer+1) mod N_REQ; pointer updates to the granted index on each transfer only.
REQ-028 SHALL without REGFILE_WR_ARB_RR_EN use fixed priority, lowest index wins; pointer logic SHALL be absent.

Structure
REQ-029 SHALL place ADDR_W derivation helper and the 16-bit count width constant in shared package regfile_pkg.
REQ-030 SHALL implement grant selection in one sub-module arb_select (inputs valid, pointer, hold; output one-hot grant).
REQ-031 SHALL connect to regfile_2r1w by o_wr_* -> i_wr_*, sharing the read addresses with the hazard inputs.

Verification
REQ-032 SHALL cover: reset, then req0 valid addr=3 data=0xAA -> ready0 same cycle, next cycle o_wr_en=1 addr=3 data=0xAA, o_wr_count=1.
REQ-033 SHALL cover: RR_EN, req0 and req1 continuously valid for 4 cycles -> grants 0,1,0,1; without macro -> 0,0,0,0.
REQ-034 SHALL cover: i_hold=1 with req0 valid for 2 cycles -> no ready, o_wr_en=0; hold drop -> grant next cycle.
REQ-035 SHALL cover: committed write to addr 5 with i_rd1_addr=5, i_rd2_addr=6 -> o_rd1_hazard=1, o_rd2_hazard=0 during that cycle only.
REQ-036 SHALL cover: rst=1 in the cycle after a grant -> o_wr_en=0, o_wr_count=0; regfile readback confirms no write.
REQ-037 SHALL cover: o_wr_count preloaded near 16'hFFFF by 65540 continuous writes -> holds at 16'hFFFF.
